// File: rtl/tick_divider_bank.sv
// Bank of NCH programmable tick generators with per-channel divisor, x1..x8 step and remainder carry.
// Optional DIVBANK_SYNC_EN adds a `sync` input that realigns the phase of every channel at once.
module tick_divider_bank #(
  parameter int CNT_W   = 24,
  parameter int CH_W    = 2,
  parameter int DEF_DIV = 24000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(1<<CH_W)-1:0]   en,
  input  logic [2*(1<<CH_W)-1:0] speed,
  input  logic                   cfg_wr,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [CNT_W-1:0]       cfg_div,
`ifdef DIVBANK_SYNC_EN
  input  logic                   sync,
`endif
  output logic                   cfg_ack,
  output logic [(1<<CH_W)-1:0]   tick,
  output logic [(1<<CH_W)-1:0]   sq
);

  localparam int NCH   = 1 << CH_W;
  localparam int SUM_W = CNT_W + 4;

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] div_q [NCH];
  logic [CNT_W-1:0] div_d [NCH];
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   sq_q, sq_d;
  logic             cfg_ack_q, cfg_ack_d;

  always_comb begin
    logic [SUM_W-1:0] step_v;
    logic [SUM_W-1:0] sum_v;
    logic [SUM_W-1:0] div_v;
    logic [SUM_W-1:0] rem_v;
    cfg_ack_d = cfg_wr;
    tick_d    = '0;
    sq_d      = sq_q;
    step_v    = '0;
    sum_v     = '0;
    div_v     = '0;
    rem_v     = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      step_v   = SUM_W'(1) << speed[2*i +: 2];
      sum_v    = {4'b0000, cnt_q[i]} + step_v;
      div_v    = {4'b0000, div_q[i]};
      rem_v    = sum_v - div_v;
      // A config write beats everything, including a terminal count in the same cycle.
      if (cfg_wr && (cfg_ch == CH_W'(i))) begin
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
`ifdef DIVBANK_SYNC_EN
      end else if (sync) begin
        cnt_d[i] = '0;
`endif
      end else if (!en[i] || (div_q[i] == '0)) begin
        cnt_d[i] = cnt_q[i];
      end else if (sum_v >= div_v) begin
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
        // When the step dwarfs the divisor the remainder is dropped rather than allowed to grow.
        cnt_d[i]  = (rem_v >= div_v) ? '0 : rem_v[CNT_W-1:0];
      end else begin
        cnt_d[i] = sum_v[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEF_DIV);
      end
      tick_q    <= '0;
      sq_q      <= '0;
      cfg_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      cfg_ack_q <= cfg_ack_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign cfg_ack = cfg_ack_q;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Randomised and directed check of tick_divider_bank against an accumulated-phase reference model.
module tb_tick_divider_bank;

  localparam int CNT_W = 24;
  localparam int CH_W  = 2;
  localparam int NCH   = 4;
  localparam int DEFD  = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic [2*NCH-1:0] speed;
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ack;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  tick_divider_bank #(.CNT_W(CNT_W), .CH_W(CH_W), .DEF_DIV(DEFD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .speed(speed), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .tick(tick), .sq(sq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each channel accumulates total phase `acc` since its last realignment and
  // has emitted `nt` ticks; a tick is due whenever acc reaches (nt+1)*div.
  longint      acc [NCH];
  longint      nt  [NCH];
  longint      mdiv[NCH];
  logic [NCH-1:0] mtick, msq;
  logic        mack;
  int          tcnt[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      acc[i] = 0; nt[i] = 0; mdiv[i] = DEFD;
    end
    mtick = '0; msq = '0; mack = 1'b0;
  endtask

  task automatic model_edge();
    longint st;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mack = cfg_wr;
    for (int i = 0; i < NCH; i++) begin
      mtick[i] = 1'b0;
      if (cfg_wr && cfg_ch == i) begin
        mdiv[i] = cfg_div; acc[i] = 0; nt[i] = 0;
      end else if (en[i] && mdiv[i] != 0) begin
        st = longint'(1) << speed[2*i +: 2];
        acc[i] += st;
        if (acc[i] >= (nt[i] + 1) * mdiv[i]) begin
          mtick[i] = 1'b1;
          msq[i]   = ~msq[i];
          nt[i]++;
          if (acc[i] >= (nt[i] + 1) * mdiv[i]) begin
            acc[i] = 0; nt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk_val("tick", 32'(tick), 32'(mtick));
      chk_val("sq", 32'(sq), 32'(msq));
      chk_val("cfg_ack", 32'(cfg_ack), 32'(mack));
      for (int i = 0; i < NCH; i++) tcnt[i] += int'(tick[i]);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
  endtask

  task automatic write_cfg(input int ch, input int dv);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv);
    cyc(1);
    cfg_wr = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_val("rst_tick", 32'(tick), 32'h0);
    chk_val("rst_sq", 32'(sq), 32'h0);
    chk_val("rst_ack", 32'(cfg_ack), 32'h0);
    cyc(2);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = '1; speed = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset(); clr_cnt();
    #1;
    chk_val("init_tick", 32'(tick), 32'h0);
    chk_val("init_sq", 32'(sq), 32'h0);
    chk_val("init_ack", 32'(cfg_ack), 32'h0);
    @(negedge clk); @(negedge clk) rst_n = 1'b1;

    // Default divisor: all channels tick on edges 10, 20, ...
    cyc(9);  chk_val("t1_pre10", 32'(tick), 32'h0);
    cyc(1);  chk_val("t1_edge10", 32'(tick), 32'hF);
             chk_val("t1_sq10", 32'(sq), 32'hF);
    cyc(10); chk_val("t1_edge20", 32'(tick), 32'hF);
             chk_val("t1_sq20", 32'(sq), 32'h0);

    // Write ch0 on the edge it would tick: suppressed, then every 3.
    cyc(9);
    write_cfg(0, 3);
    chk_val("t3_tick30", 32'(tick), 32'hE);
    chk_val("t3_ack", 32'(cfg_ack), 32'h1);
    cyc(2);  chk_val("t3_pre33", 32'(tick[0]), 32'h0);
    cyc(1);  chk_val("t3_edge33", 32'(tick), 32'h1);

    // Speed multipliers: x2 on div 10, x8 on div 12.
    speed = 8'b00_11_01_00;
    write_cfg(1, 10);
    write_cfg(2, 12);
    clr_cnt(); cyc(30);
    chk_val("t2_ch1_ticks", 32'(tcnt[1]), 32'd6);
    chk_val("t2_ch2_ticks", 32'(tcnt[2]), 32'd20);

    // Parked channel, then div 1 at x8.
    write_cfg(3, 0);
    clr_cnt(); cyc(20);
    chk_val("t4_parked", 32'(tcnt[3]), 32'd0);
    speed = 8'b11_11_01_00;
    write_cfg(3, 1);
    clr_cnt(); cyc(5);
    chk_val("t4_every", 32'(tcnt[3]), 32'd5);

    // Enable gap freezes the count at 4 of 10.
    speed = '0;
    write_cfg(0, 10);
    cyc(4);
    en[0] = 1'b0;
    clr_cnt(); cyc(7);
    chk_val("t5_gap", 32'(tcnt[0]), 32'd0);
    en[0] = 1'b1;
    cyc(5);  chk_val("t5_pre", 32'(tick[0]), 32'h0);
    cyc(1);  chk_val("t5_resume", 32'(tick[0]), 32'h1);

    // Mid-run asynchronous reset.
    cyc(3);
    async_reset();
    en = '1; speed = '0;
    cyc(9);  chk_val("t6_pre10", 32'(tick), 32'h0);
    cyc(1);  chk_val("t6_edge10", 32'(tick), 32'hF);

    // Random traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) speed = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr  = 1'b1;
        cfg_ch  = CH_W'($urandom_range(0, NCH-1));
        cfg_div = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 3))
                                             : CNT_W'($urandom_range(0, 25));
      end else begin
        cfg_wr = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) async_reset();
      else cyc(1);
    end
    cfg_wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
